// File: rtl/prod_sum_seq_if.sv
// Handshake and operand bus for prod_sum_seq.
// PROD_SUM_SEQ_SAT_EN adds the sticky ovf flag.
interface prod_sum_seq_if #(
  parameter int A_WIDTH    = 2,
  parameter int B_WIDTH    = 2,
  parameter int NUM_INPUTS = 2,
  parameter int SUM_WIDTH  = 4
);
  logic                          start;
  logic                          hold;
  logic                          tc;
  logic [A_WIDTH*NUM_INPUTS-1:0] a;
  logic [B_WIDTH*NUM_INPUTS-1:0] b;
  logic                          busy;
  logic                          complete;
  logic [SUM_WIDTH-1:0]          sum;
`ifdef PROD_SUM_SEQ_SAT_EN
  logic                          ovf;

  modport master (output start, hold, tc, a, b, input busy, complete, sum, ovf);
  modport slave  (input start, hold, tc, a, b, output busy, complete, sum, ovf);
`else
  modport master (output start, hold, tc, a, b, input busy, complete, sum);
  modport slave  (input start, hold, tc, a, b, output busy, complete, sum);
`endif
endinterface

// File: rtl/prod_sum_seq.sv
// Sequential product-sum: one a[i]*b[i] term accumulated per clock.
// Define PROD_SUM_SEQ_SAT_EN for saturating accumulation with a sticky ovf flag.
module prod_sum_seq #(
  parameter int A_WIDTH    = 2,
  parameter int B_WIDTH    = 2,
  parameter int NUM_INPUTS = 2,
  parameter int SUM_WIDTH  = 4
) (
  input logic          clk,
  input logic          rst,
  prod_sum_seq_if.slave bus
);

  localparam int PW    = A_WIDTH + B_WIDTH;
  localparam int EW    = ((PW > SUM_WIDTH) ? PW : SUM_WIDTH) + 1;
  localparam int IDX_W = $clog2(NUM_INPUTS + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_INPUTS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                        state, state_n;
  logic [A_WIDTH*NUM_INPUTS-1:0] a_q, a_n;
  logic [B_WIDTH*NUM_INPUTS-1:0] b_q, b_n;
  logic                          tc_q, tc_n;
  logic [IDX_W-1:0]              idx, idx_n;
  logic [SUM_WIDTH-1:0]          acc, acc_n;
  logic [SUM_WIDTH-1:0]          sum_q, sum_n;
  logic [SUM_WIDTH-1:0]          acc_step;
  logic                          step_ovf;

  logic [A_WIDTH-1:0]            a_i;
  logic [B_WIDTH-1:0]            b_i;
  logic [EW-1:0]                 a_e, b_e;
  logic [SUM_WIDTH-1:0]          term;

  // Multiplying operands extended past the product width and keeping the low
  // SUM_WIDTH bits yields the full-width product sign/zero-extended or truncated.
  always_comb begin
    a_i  = a_q[int'(idx) * A_WIDTH +: A_WIDTH];
    b_i  = b_q[int'(idx) * B_WIDTH +: B_WIDTH];
    a_e  = {{(EW - A_WIDTH){tc_q & a_i[A_WIDTH-1]}}, a_i};
    b_e  = {{(EW - B_WIDTH){tc_q & b_i[B_WIDTH-1]}}, b_i};
    term = SUM_WIDTH'(a_e * b_e);
  end

`ifdef PROD_SUM_SEQ_SAT_EN
  localparam logic [SUM_WIDTH-1:0] SMIN = SUM_WIDTH'(1) << (SUM_WIDTH - 1);
  localparam logic [SUM_WIDTH-1:0] SMAX = ~SMIN;

  logic [SUM_WIDTH:0] ext_sum;
  logic               ovf_q, ovf_n;

  always_comb begin
    ext_sum  = {tc_q & acc[SUM_WIDTH-1], acc} + {tc_q & term[SUM_WIDTH-1], term};
    step_ovf = 1'b0;
    acc_step = ext_sum[SUM_WIDTH-1:0];
    if (tc_q) begin
      if (ext_sum[SUM_WIDTH] != ext_sum[SUM_WIDTH-1]) begin
        step_ovf = 1'b1;
        acc_step = ext_sum[SUM_WIDTH] ? SMIN : SMAX;
      end
    end else if (ext_sum[SUM_WIDTH]) begin
      step_ovf = 1'b1;
      acc_step = '1;
    end
  end

  assign bus.ovf = ovf_q;
`else
  always_comb begin
    acc_step = acc + term;
    step_ovf = 1'b0;
  end
`endif

  always_comb begin
    state_n = state;
    a_n     = a_q;
    b_n     = b_q;
    tc_n    = tc_q;
    idx_n   = idx;
    acc_n   = acc;
    sum_n   = sum_q;
`ifdef PROD_SUM_SEQ_SAT_EN
    ovf_n   = ovf_q;
`endif
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_n = RUN;
          a_n     = bus.a;
          b_n     = bus.b;
          tc_n    = bus.tc;
          idx_n   = '0;
          acc_n   = '0;
`ifdef PROD_SUM_SEQ_SAT_EN
          ovf_n   = 1'b0;
`endif
        end
      end
      RUN: begin
        if (!bus.hold) begin
          acc_n = acc_step;
          idx_n = idx + IDX_W'(1);
`ifdef PROD_SUM_SEQ_SAT_EN
          ovf_n = ovf_q | step_ovf;
`endif
          if (idx == LAST) begin
            state_n = DONE;
            sum_n   = acc_step;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      tc_q  <= 1'b0;
      idx   <= '0;
      acc   <= '0;
      sum_q <= '0;
`ifdef PROD_SUM_SEQ_SAT_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      state <= state_n;
      a_q   <= a_n;
      b_q   <= b_n;
      tc_q  <= tc_n;
      idx   <= idx_n;
      acc   <= acc_n;
      sum_q <= sum_n;
`ifdef PROD_SUM_SEQ_SAT_EN
      ovf_q <= ovf_n;
`endif
    end
  end

  assign bus.busy     = (state == RUN);
  assign bus.complete = (state == DONE);
  assign bus.sum      = sum_q;

endmodule
